// File: rtl/field_blink_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : field_blink_ctrl
// Description : N-field blink controller for the clock/alarm setting display.
//               Runs on the divided blink tick. It blanks the field under edit
//               with an asymmetric SHOW/HIDE phase and restarts the phase on
//               every keypress or position change, so the edited field is lit
//               right after user input. It also raises a one-tick inactivity
//               timeout so the mode controller can leave setting mode.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: FIELD_BLINK_ALL_EN
//   defined   : setting_mode 3 is an active blink mode that flashes the whole
//               display. The inactivity timer does not run in mode 3.
//   undefined : setting_mode 3 behaves like run mode.
// ----------------------------------------------------------------------------
// Ports:
//   blink_clk        in   1         divided blink tick (nominally 2 Hz)
//   rst_n            in   1         asynchronous active-low reset
//   setting_mode     in   2         0 run, 1 time set, 2 alarm set, 3 special
//   setting_position in   POS_W     index of the field under edit
//   i_key            in   1         synchronised one-tick keypress pulse
//   i_dis            in   N_FIELDS  per-field enable from upstream (1 = lit)
//   o_dis            out  N_FIELDS  per-field enable after blanking (1 = lit)
//   o_blink          out  1         high while the FSM is in HIDE
//   o_timeout        out  1         one-tick inactivity pulse
// ============================================================================
module field_blink_ctrl #(
  parameter int N_FIELDS      = 3,
  parameter int POS_W         = 2,
  parameter int ON_TICKS      = 1,
  parameter int OFF_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic                blink_clk,
  input  logic                rst_n,
  input  logic [1:0]          setting_mode,
  input  logic [POS_W-1:0]    setting_position,
  input  logic                i_key,
  input  logic [N_FIELDS-1:0] i_dis,
  output logic [N_FIELDS-1:0] o_dis,
  output logic                o_blink,
  output logic                o_timeout
);

  localparam logic [15:0] ON_LAST     = 16'(ON_TICKS - 1);
  localparam logic [15:0] OFF_LAST    = 16'(OFF_TICKS - 1);
  localparam logic [15:0] TIMEOUT_MAX = 16'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_HIDE = 2'd2
  } state_t;

  state_t              state_q,   state_d;
  logic [15:0]         phase_q,   phase_d;
  logic [15:0]         idle_q,    idle_d;
  logic [POS_W-1:0]    pos_q,     pos_d;
  logic [N_FIELDS-1:0] dis_q,     dis_d;
  logic                blink_q,   blink_d;
  logic                timeout_q, timeout_d;

  logic                setting_active;
  logic                all_fields;
  logic                idle_run;
  logic                restart;
  logic [N_FIELDS-1:0] field_sel;
  logic [N_FIELDS-1:0] mask;

  // Mode decode: which modes blink, which blink everything, which are timed.
  always_comb begin
`ifdef FIELD_BLINK_ALL_EN
    setting_active = (setting_mode != 2'd0);
    all_fields     = (setting_mode == 2'd3);
    idle_run       = (setting_mode == 2'd1) || (setting_mode == 2'd2);
`else
    setting_active = (setting_mode == 2'd1) || (setting_mode == 2'd2);
    all_fields     = 1'b0;
    idle_run       = setting_active;
`endif
  end

  // One-hot field select; a position outside 0..N_FIELDS-1 matches nothing,
  // so an out-of-range position simply blanks no field.
  always_comb begin
    field_sel = '0;
    for (int i = 0; i < N_FIELDS; i++) begin
      field_sel[i] = (setting_position == POS_W'(i));
    end
  end

  assign restart = i_key || (setting_position != pos_q);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pos_d   = setting_position;

    // Leaving setting mode overrides a restart and the phase sequencing.
    if (!setting_active) begin
      state_d = ST_IDLE;
      phase_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          phase_d = '0;
        end
        ST_SHOW: begin
          if (restart) begin
            state_d = ST_SHOW;
            phase_d = '0;
          end else if (phase_q == ON_LAST) begin
            state_d = ST_HIDE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 16'd1;
          end
        end
        ST_HIDE: begin
          if (restart) begin
            state_d = ST_SHOW;
            phase_d = '0;
          end else if (phase_q == OFF_LAST) begin
            state_d = ST_SHOW;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          phase_d = '0;
        end
      endcase
    end

    // Blanking follows the pre-edge state, so o_dis lags the FSM by one tick.
    if (state_q == ST_HIDE) begin
      mask = all_fields ? {N_FIELDS{1'b1}} : field_sel;
    end else begin
      mask = '0;
    end
    dis_d   = i_dis & ~mask;
    blink_d = (state_d == ST_HIDE);

    // Inactivity counter saturates, so the timeout fires once per idle spell.
    if (!idle_run || i_key) begin
      idle_d = '0;
    end else if (idle_q != TIMEOUT_MAX) begin
      idle_d = idle_q + 16'd1;
    end else begin
      idle_d = idle_q;
    end
    timeout_d = (idle_d == TIMEOUT_MAX) && (idle_q != TIMEOUT_MAX);
  end

  always_ff @(posedge blink_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      idle_q    <= '0;
      pos_q     <= '0;
      dis_q     <= {N_FIELDS{1'b1}};
      blink_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idle_q    <= idle_d;
      pos_q     <= pos_d;
      dis_q     <= dis_d;
      blink_q   <= blink_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_dis     = dis_q;
  assign o_blink   = blink_q;
  assign o_timeout = timeout_q;

endmodule
`default_nettype wire

// File: doc/field_blink_ctrl.md
Name: field_blink_ctrl

Overview:
- Parametrised blink controller for the clock/alarm setting display; generalises the 3-field (hour/min/sec) blinker to N fields.
- Runs on the divided blink tick and generates an asymmetric on/off blink phase for the field under edit.
- Restarts the phase on every position change or keypress, so the edited field is always visible right after user input.
- Raises a one-tick inactivity timeout so the mode controller can leave setting mode.

Parameters:
- N_FIELDS, 3, number of display fields, 2..8; field 0 = sec, 1 = min, 2 = hour.
- POS_W, 2, width of setting_position; 2^POS_W >= N_FIELDS.
- ON_TICKS, 1, blink_clk ticks the selected field is shown per cycle, 1..65535.
- OFF_TICKS, 1, blink_clk ticks the selected field is blanked per cycle, 1..65535.
- TIMEOUT_TICKS, 20, ticks without keypress in setting mode before o_timeout, 1..65535.

Ports:
- blink_clk  in  1  block clock (divided blink tick, nominally 2 Hz)
- rst_n  in  1  asynchronous, active-low reset
- setting_mode  in  2  0 = run; 1 = time set; 2 = alarm set; 3 = reserved (see optional feature)
- setting_position  in  POS_W  index of the field under edit
- i_key  in  1  keypress pulse, one blink_clk tick wide, already synchronised
- i_dis  in  N_FIELDS  per-field display enable from upstream (1 = lit)
- o_dis  out  N_FIELDS  per-field display enable after blanking (1 = lit)
- o_blink  out  1  1 while in HIDE state
- o_timeout  out  1  one-tick inactivity pulse

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; phase counter = 0; idle counter = 0.
  - o_dis = all ones; o_blink = 0; o_timeout = 0.
- Setting is active when setting_mode is 1 or 2.
- FSM (registered, one transition per blink_clk tick):
  - IDLE: if setting active -> SHOW, phase counter = 0.
  - SHOW: increment phase counter; on the tick it reaches ON_TICKS-1 -> HIDE, counter = 0.
  - HIDE: increment phase counter; on the tick it reaches OFF_TICKS-1 -> SHOW, counter = 0.
  - From SHOW or HIDE: setting inactive -> IDLE, counter = 0. This has priority over everything else.
  - Restart: i_key = 1, or setting_position differs from its previous-tick registered copy -> SHOW, counter = 0. Restart has priority over the normal SHOW/HIDE transition.
- Blanking mask: one-hot of setting_position, only when state == HIDE. A position >= N_FIELDS gives an all-zero mask (nothing blinks, no error).
- o_dis is registered: o_dis <= i_dis & ~mask, where mask comes from the current (pre-edge) state. Latency is 1 tick from a state change to o_dis.
- o_blink is registered: o_blink <= (next state == HIDE).
- Idle counter (16 bit):
  - Cleared by i_key, and whenever not in setting mode.
  - Otherwise increments, saturating at TIMEOUT_TICKS.
  - o_timeout = 1 for exactly the one tick on which the counter transitions to TIMEOUT_TICKS.
  - No re-fire until the counter is cleared.
  - Blinking continues after timeout until the mode changes.
- Simultaneous setting exit and i_key: exit wins; state = IDLE; idle counter cleared.
- Mode change 1 <-> 2 directly: both count as setting, so no restart unless position also changes or a key is pressed.
- Reset mid-blink: immediate return to the reset values above; no partial outputs.

Optional Feature:
- Macro: FIELD_BLINK_ALL_EN.
- Defined: setting_mode == 3 counts as setting active with mask = all ones in HIDE (whole display flashes, e.g. alarm ringing). i_key still restarts SHOW. The timeout counter does not run in mode 3.
- Undefined: mode 3 is treated as run mode (IDLE, no blanking, no timeout).

Test Plan:
- Test parameters for all cases: N_FIELDS=3, ON_TICKS=2, OFF_TICKS=2, TIMEOUT_TICKS=10.
- Reset, then mode=1, pos=1, i_dis=3'b111 -> o_dis=111,111,101,101,111,... (period 4 ticks after 1-tick entry); o_blink mirrors the HIDE ticks; reassert rst_n=0 mid-HIDE -> o_dis=111 immediately.
- Mode=1 in HIDE on pos 0; change pos to 2 -> next state SHOW; o_dis=111 for 2 ticks, then 011.
- Mode=2, no keys -> o_timeout high on exactly tick 10, never again; i_key at tick 12 then idle -> new pulse 10 ticks later.
- pos=3 (invalid) in mode 1 -> o_dis == i_dis every tick; o_blink still toggles.
- Mode 1 -> 0 on the same tick as i_key -> IDLE, o_dis follows i_dis (e.g. 3'b010 -> 010 next tick), o_timeout never fires.
- With FIELD_BLINK_ALL_EN: mode=3 -> o_dis alternates 111/000 every 2 ticks. Without the macro: mode=3 -> o_dis=111 constant.
